// File: rtl/display_scheduler_pkg.sv
// Shared types and constants for the display scheduler: service codes,
// FSM states, anode/segment patterns and small decode helpers.
package display_scheduler_pkg;

  typedef enum logic [3:0] {
    SVC_RESET = 4'b0000,
    SVC_S1    = 4'b1000,
    SVC_S2    = 4'b0100,
    SVC_S3    = 4'b0010,
    SVC_S4    = 4'b0001
  } service_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ACTIVE
  } state_e;

  // Anodes are active-low; the board wiring gives this non-sequential order.
  localparam logic [3:0] ANODE_OFF  = 4'b1111;
  localparam logic [3:0] ANODE_DIG0 = 4'b1011;
  localparam logic [3:0] ANODE_DIG1 = 4'b0111;
  localparam logic [3:0] ANODE_DIG2 = 4'b1110;
  localparam logic [3:0] ANODE_DIG3 = 4'b1101;

  // Segments are active-low, ordered {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK  = 7'b1111111;
  localparam logic [6:0] SEG_DASH   = 7'b0111111;
  localparam logic [6:0] SEG_ALL_ON = 7'b0000000;

  function automatic logic is_valid_mode(input logic [3:0] m);
    logic ok;
    ok = 1'b0;
    case (m)
      SVC_S1, SVC_S2, SVC_S3, SVC_S4: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] anode_for(input logic [1:0] idx);
    logic [3:0] an;
    an = ANODE_OFF;
    case (idx)
      2'd0:    an = ANODE_DIG0;
      2'd1:    an = ANODE_DIG1;
      2'd2:    an = ANODE_DIG2;
      default: an = ANODE_DIG3;
    endcase
    return an;
  endfunction

endpackage

// File: rtl/display_scheduler_bcd_to_seg.sv
// Combinational BCD digit to active-low 7-segment decode; A-F show blank.
module bcd_to_seg
  import display_scheduler_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = 7'b1000000;
      4'd1:    seg_o = 7'b1111001;
      4'd2:    seg_o = 7'b0100100;
      4'd3:    seg_o = 7'b0110000;
      4'd4:    seg_o = 7'b0011001;
      4'd5:    seg_o = 7'b0010010;
      4'd6:    seg_o = 7'b0000010;
      4'd7:    seg_o = 7'b1111000;
      4'd8:    seg_o = 7'b0000000;
      4'd9:    seg_o = 7'b0010000;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scheduler.sv
// Four-service multiplexed 7-segment display scheduler: a mode switch must be
// stable for SETTLE_TICKS scan ticks before its service is granted the display.
module display_scheduler
  import display_scheduler_pkg::*;
#(
  parameter int unsigned SCAN_DIV_W   = 16,
  parameter int unsigned SETTLE_TICKS = 4,
  parameter int unsigned BLINK_W      = 25
) (
  input  logic        clk_osc,
  input  logic        reset,
  input  logic [3:0]  mode_sw,
  input  logic [15:0] svc_data0,
  input  logic [15:0] svc_data1,
  input  logic [15:0] svc_data2,
  input  logic [15:0] svc_data3,
  input  logic [3:0]  svc_valid,
  input  logic        alarm_req,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic [3:0]  grant,
  output logic        settling
);

  localparam int unsigned      CNT_W       = $clog2(SETTLE_TICKS + 1);
  localparam logic [CNT_W-1:0] SETTLE_DONE = CNT_W'(SETTLE_TICKS);

  state_e                state_q, state_d;
  service_e              cand_q, cand_d;
  service_e              grant_q, grant_d;
  logic [CNT_W-1:0]      settle_q, settle_d;
  logic [SCAN_DIV_W-1:0] scan_q, scan_d;
  logic [1:0]            digit_q, digit_d;
  logic [BLINK_W-1:0]    blink_q, blink_d;
  logic [3:0]            anode_q, anode_d;
  logic [6:0]            seg_q, seg_d;

  logic                  scan_tick;
  logic                  mode_ok;
  logic [CNT_W-1:0]      settle_inc;
  logic [15:0]           svc_word;
  logic                  svc_ok;
  logic [3:0]            nibble;
  logic [6:0]            dec_seg;
  logic [3:0]            digit_anode;

  always_comb begin
    scan_tick = &scan_q;
    scan_d    = scan_q + SCAN_DIV_W'(1);
    digit_d   = scan_tick ? digit_q + 2'd1 : digit_q;
    blink_d   = blink_q + BLINK_W'(1);
  end

  // A mode change always takes priority over the tick in the same cycle, so the
  // new value restarts settling instead of counting.
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    grant_d    = grant_q;
    settle_d   = settle_q;
    mode_ok    = is_valid_mode(mode_sw);
    settle_inc = settle_q + CNT_W'(1);
    case (state_q)
      ST_IDLE: begin
        grant_d = SVC_RESET;
        if (mode_ok) begin
          state_d  = ST_SETTLE;
          cand_d   = service_e'(mode_sw);
          settle_d = '0;
        end
      end
      ST_SETTLE: begin
        if (!mode_ok) begin
          state_d = ST_IDLE;
          grant_d = SVC_RESET;
        end else if (mode_sw != cand_q) begin
          cand_d   = service_e'(mode_sw);
          settle_d = '0;
        end else if (scan_tick) begin
          if (settle_inc == SETTLE_DONE) begin
            state_d  = ST_ACTIVE;
            grant_d  = cand_q;
            settle_d = '0;
          end else begin
            settle_d = settle_inc;
          end
        end
      end
      ST_ACTIVE: begin
        if (!mode_ok) begin
          state_d = ST_IDLE;
          grant_d = SVC_RESET;
        end else if (mode_sw != grant_q) begin
          state_d  = ST_SETTLE;
          cand_d   = service_e'(mode_sw);
          settle_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = SVC_RESET;
      end
    endcase
  end

  // Display path is driven from next-state values so the registered outputs
  // line up with the grant, digit index and blink phase they describe.
  always_comb begin
    svc_word = '0;
    svc_ok   = 1'b0;
    case (grant_d)
      SVC_S1:  begin svc_word = svc_data0; svc_ok = svc_valid[3]; end
      SVC_S2:  begin svc_word = svc_data1; svc_ok = svc_valid[2]; end
      SVC_S3:  begin svc_word = svc_data2; svc_ok = svc_valid[1]; end
      SVC_S4:  begin svc_word = svc_data3; svc_ok = svc_valid[0]; end
      default: begin svc_word = '0;        svc_ok = 1'b0;         end
    endcase
    case (digit_d)
      2'd0:    nibble = svc_word[3:0];
      2'd1:    nibble = svc_word[7:4];
      2'd2:    nibble = svc_word[11:8];
      default: nibble = svc_word[15:12];
    endcase
  end

  bcd_to_seg u_bcd_to_seg (
    .bcd_i (nibble),
    .seg_o (dec_seg)
  );

  always_comb begin
    digit_anode = anode_for(digit_d);
    anode_d     = ANODE_OFF;
    seg_d       = SEG_BLANK;
    if (alarm_req) begin
      if (blink_d[BLINK_W-1]) begin
        anode_d = digit_anode;
        seg_d   = SEG_ALL_ON;
      end
    end else if (grant_d != SVC_RESET) begin
      anode_d = digit_anode;
      seg_d   = svc_ok ? dec_seg : SEG_DASH;
    end
  end

  always_ff @(posedge clk_osc) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cand_q   <= SVC_RESET;
      grant_q  <= SVC_RESET;
      settle_q <= '0;
      scan_q   <= '0;
      digit_q  <= '0;
      blink_q  <= '0;
      anode_q  <= ANODE_OFF;
      seg_q    <= SEG_BLANK;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      grant_q  <= grant_d;
      settle_q <= settle_d;
      scan_q   <= scan_d;
      digit_q  <= digit_d;
      blink_q  <= blink_d;
      anode_q  <= anode_d;
      seg_q    <= seg_d;
    end
  end

  assign anode    = anode_q;
  assign seg      = seg_q;
  assign grant    = grant_q;
  assign settling = (state_q == ST_SETTLE);

endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler: cycle-count based reference model checked every
// clock, directed scenarios with literal expectations, then randomized traffic.
module tb_display_scheduler;

  localparam int SCAN_W = 2;
  localparam int SETTLE = 4;
  localparam int BW     = 4;
  localparam int P      = 1 << SCAN_W;

  localparam int M_IDLE   = 0;
  localparam int M_SETTLE = 1;
  localparam int M_ACTIVE = 2;

  logic        clk_osc = 1'b0;
  logic        reset;
  logic [3:0]  mode_sw;
  logic [15:0] svc_data0, svc_data1, svc_data2, svc_data3;
  logic [3:0]  svc_valid;
  logic        alarm_req;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic [3:0]  grant;
  logic        settling;

  int checks = 0;
  int errors = 0;

  // Model state: m_c is clocks elapsed since the last reset edge.
  logic        m_ready = 1'b0;
  logic        m_rst;
  int          m_c, m_st, m_cnt;
  logic [3:0]  m_cand, m_grant;
  logic        m_alarm;
  logic [15:0] m_data [4];
  logic [3:0]  m_valid;

  display_scheduler #(
    .SCAN_DIV_W   (SCAN_W),
    .SETTLE_TICKS (SETTLE),
    .BLINK_W      (BW)
  ) dut (
    .clk_osc   (clk_osc),
    .reset     (reset),
    .mode_sw   (mode_sw),
    .svc_data0 (svc_data0),
    .svc_data1 (svc_data1),
    .svc_data2 (svc_data2),
    .svc_data3 (svc_data3),
    .svc_valid (svc_valid),
    .alarm_req (alarm_req),
    .anode     (anode),
    .seg       (seg),
    .grant     (grant),
    .settling  (settling)
  );

  always #5 clk_osc = ~clk_osc;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_anode(input int d);
    logic [3:0] a;
    case (d)
      0:       a = 4'b1011;
      1:       a = 4'b0111;
      2:       a = 4'b1110;
      default: a = 4'b1101;
    endcase
    return a;
  endfunction

  // Active-high gfedcba patterns, inverted for the active-low display.
  function automatic logic [6:0] exp_digit(input logic [3:0] n);
    logic [6:0] lit;
    case (n)
      4'd0:    lit = 7'h3F;
      4'd1:    lit = 7'h06;
      4'd2:    lit = 7'h5B;
      4'd3:    lit = 7'h4F;
      4'd4:    lit = 7'h66;
      4'd5:    lit = 7'h6D;
      4'd6:    lit = 7'h7D;
      4'd7:    lit = 7'h07;
      4'd8:    lit = 7'h7F;
      4'd9:    lit = 7'h6F;
      default: lit = 7'h00;
    endcase
    return ~lit;
  endfunction

  task automatic model_edge();
    logic tick;
    logic ok;
    if (reset) begin
      m_ready = 1'b1;
      m_rst   = 1'b1;
      m_c     = 0;
      m_st    = M_IDLE;
      m_cnt   = 0;
      m_cand  = 4'b0000;
      m_grant = 4'b0000;
    end else if (m_ready) begin
      tick = (m_c % P) == P - 1;
      ok   = $countones(mode_sw) == 1;
      if (!ok) begin
        m_st    = M_IDLE;
        m_grant = 4'b0000;
      end else if (m_st == M_IDLE || mode_sw != m_cand) begin
        m_st   = M_SETTLE;
        m_cand = mode_sw;
        m_cnt  = 0;
      end else if (m_st == M_SETTLE && tick) begin
        m_cnt++;
        if (m_cnt == SETTLE) begin
          m_st    = M_ACTIVE;
          m_grant = m_cand;
        end
      end
      m_c++;
      m_rst = 1'b0;
    end
    m_alarm   = alarm_req;
    m_data[0] = svc_data0;
    m_data[1] = svc_data1;
    m_data[2] = svc_data2;
    m_data[3] = svc_data3;
    m_valid   = svc_valid;
  endtask

  task automatic model_outputs(output logic [3:0] an, output logic [6:0] sg);
    int          d;
    int          b;
    logic        ph;
    logic [15:0] w;
    d  = (m_c / P) % 4;
    ph = ((m_c >> (BW - 1)) & 1) == 1;
    b  = 0;
    an = 4'b1111;
    sg = 7'b1111111;
    if (m_rst) begin
      an = 4'b1111;
    end else if (m_alarm) begin
      if (ph) begin
        an = exp_anode(d);
        sg = 7'b0000000;
      end
    end else if (m_grant != 4'b0000) begin
      for (int i = 0; i < 4; i++) if (m_grant[i]) b = i;
      an = exp_anode(d);
      if (!m_valid[b]) sg = 7'b0111111;
      else begin
        w  = m_data[3 - b];
        sg = exp_digit(w[d*4 +: 4]);
      end
    end
  endtask

  // Compare process: model advances on each edge, outputs checked 2ns later.
  initial begin : compare
    logic [3:0] ea;
    logic [6:0] es;
    forever begin
      @(posedge clk_osc);
      #2;
      model_edge();
      if (m_ready) begin
        model_outputs(ea, es);
        check("m_anode",    16'(anode),    16'(ea));
        check("m_seg",      16'(seg),      16'(es));
        check("m_grant",    16'(grant),    16'(m_grant));
        check("m_settling", 16'(settling), 16'(m_st == M_SETTLE));
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk_osc);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wait_n(1);
    reset = 1'b0;
  endtask

  initial begin : stim
    int         r;
    int         hold;
    logic [3:0] m;
    reset     = 1'b1;
    mode_sw   = 4'b0000;
    svc_data0 = '0;
    svc_data1 = '0;
    svc_data2 = '0;
    svc_data3 = '0;
    svc_valid = 4'b0000;
    alarm_req = 1'b0;
    wait_n(3);
    check("rst_anode",    16'(anode),    16'(4'b1111));
    check("rst_seg",      16'(seg),      16'(7'b1111111));
    check("rst_grant",    16'(grant),    16'(4'b0000));
    check("rst_settling", 16'(settling), 16'(1'b0));

    // Settle S1, then walk the four digits.
    reset     = 1'b0;
    mode_sw   = 4'b1000;
    svc_data0 = 16'h1234;
    svc_valid = 4'b1000;
    wait_n(15);
    check("a_settling", 16'(settling), 16'(1'b1));
    check("a_nogrant",  16'(grant),    16'(4'b0000));
    wait_n(1);
    check("a_grant",    16'(grant),    16'(4'b1000));
    check("a_an0",      16'(anode),    16'(4'b1011));
    check("a_seg0",     16'(seg),      16'(7'b0011001));
    wait_n(4);
    check("a_an1",      16'(anode),    16'(4'b0111));
    check("a_seg1",     16'(seg),      16'(7'b0110000));
    wait_n(4);
    check("a_an2",      16'(anode),    16'(4'b1110));
    check("a_seg2",     16'(seg),      16'(7'b0100100));
    wait_n(4);
    check("a_an3",      16'(anode),    16'(4'b1101));
    check("a_seg3",     16'(seg),      16'(7'b1111001));

    // Switch S2 briefly, then S3: old grant persists until S3 settles.
    mode_sw = 4'b0100;
    wait_n(8);
    check("b_hold_grant", 16'(grant), 16'(4'b1000));
    mode_sw   = 4'b0010;
    svc_valid = 4'b1111;
    wait_n(15);
    check("b_still_old", 16'(grant),    16'(4'b1000));
    check("b_settling",  16'(settling), 16'(1'b1));
    wait_n(1);
    check("b_new_grant", 16'(grant), 16'(4'b0010));

    // Invalid codes drop to idle within one clock.
    mode_sw = 4'b1100;
    wait_n(1);
    check("c_grant_1100", 16'(grant), 16'(4'b0000));
    check("c_anode_1100", 16'(anode), 16'(4'b1111));
    mode_sw = 4'b0100;
    wait_n(3);
    mode_sw = 4'b0000;
    wait_n(1);
    check("c_settle_0000", 16'(settling), 16'(1'b0));
    check("c_anode_0000",  16'(anode),    16'(4'b1111));

    // S2 invalid data shows dashes; then a blank A-F nibble.
    do_reset();
    mode_sw   = 4'b0100;
    svc_data1 = 16'h00F5;
    svc_valid = 4'b1011;
    wait_n(16);
    check("d_grant", 16'(grant), 16'(4'b0100));
    check("d_dash",  16'(seg),   16'(7'b0111111));
    svc_valid = 4'b1111;
    wait_n(1);
    check("d_five",  16'(seg),   16'(7'b0010010));
    wait_n(4);
    check("d_an1",   16'(anode), 16'(4'b0111));
    check("d_blank", 16'(seg),   16'(7'b1111111));

    // Alarm blink while active.
    do_reset();
    mode_sw   = 4'b1000;
    svc_data0 = 16'h1234;
    svc_valid = 4'b1000;
    wait_n(16);
    alarm_req = 1'b1;
    wait_n(1);
    check("e_off_an",  16'(anode), 16'(4'b1111));
    wait_n(8);
    check("e_on_an",   16'(anode), 16'(4'b1110));
    check("e_on_seg",  16'(seg),   16'(7'b0000000));
    alarm_req = 1'b0;
    wait_n(1);
    check("e_back_an",  16'(anode), 16'(4'b1110));
    check("e_back_seg", 16'(seg),   16'(7'b0100100));

    // Reset mid-settle restarts the full settle period.
    do_reset();
    mode_sw = 4'b1000;
    wait_n(12);
    reset = 1'b1;
    wait_n(1);
    check("f_rst_an",     16'(anode),    16'(4'b1111));
    check("f_rst_seg",    16'(seg),      16'(7'b1111111));
    check("f_rst_settle", 16'(settling), 16'(1'b0));
    reset = 1'b0;
    wait_n(15);
    check("f_not_yet", 16'(grant), 16'(4'b0000));
    wait_n(1);
    check("f_grant",   16'(grant), 16'(4'b1000));

    // Randomized traffic against the model.
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70) begin
        mode_sw = 4'(1 << $urandom_range(0, 3));
      end else if (r < 85) begin
        m = 4'($urandom_range(0, 15));
        while ($countones(m) == 1) m = 4'($urandom_range(0, 15));
        mode_sw = m;
      end
      if ($urandom_range(0, 1) == 0) begin
        svc_data0 = 16'($urandom);
        svc_data1 = 16'($urandom);
        svc_data2 = 16'($urandom);
        svc_data3 = 16'($urandom);
      end else begin
        svc_data0 = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        svc_data1 = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        svc_data2 = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        svc_data3 = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      end
      svc_valid = 4'($urandom_range(0, 15));
      alarm_req = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 30) == 0) do_reset();
      hold = int'($urandom_range(1, 40));
      wait_n(hold);
    end

    wait_n(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scheduler.md
DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 SHALL have parameter SCAN_DIV_W, default 16; a scan tick occurs every 2^SCAN_DIV_W clocks.
REQ-002 SHALL have parameter SETTLE_TICKS, default 4; a new mode must be held stable for this many scan ticks before it is granted.
REQ-003 SHALL have parameter BLINK_W, default 25; the alarm blink phase is bit BLINK_W-1 of a free-running counter.
REQ-004 clk_osc  in  1  single clock; all logic is on its rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 mode_sw  in  4  service select: 1000=S1, 0100=S2, 0010=S3, 0001=S4; any other value is invalid.
REQ-007 svc_data0..svc_data3  in  16 each  4-digit BCD from each service; [3:0] is digit 0, [15:12] is digit 3.
REQ-008 svc_valid  in  4  per-service data-valid; bit 3 is S1 and bit 0 is S4, matching mode_sw.
REQ-009 alarm_req  in  1  flash override request.
REQ-010 anode  out  4  active-low digit enable.
REQ-011 seg  out  7  active-low segments, {g,f,e,d,c,b,a}.
REQ-012 grant  out  4  one-hot service currently displayed; 0000 when none.
REQ-013 settling  out  1  high while in SETTLE.

Function
REQ-014 SHALL divide the clock with a free-running SCAN_DIV_W-bit counter that wraps; scan_tick is asserted for one cycle when the counter reaches all-ones.
REQ-015 SHALL advance a 2-bit digit index by 1 (mod 4) on each scan_tick.
REQ-016 SHALL map digit index to anode as follows: 0 -> 1011, 1 -> 0111, 2 -> 1110, 3 -> 1101.
REQ-017 SHALL register anode and seg, so that both change exactly one clock after a scan_tick.
REQ-018 FSM SHALL have three states:
- IDLE: grant=0000, anode=1111.
- SETTLE: candidate held in a register.
- ACTIVE: grant=candidate.
REQ-019 IDLE -> SETTLE when mode_sw is valid; candidate is loaded and the settle count is cleared.
REQ-020 SETTLE: on each scan_tick with mode_sw equal to candidate, the settle count increments; when it reaches SETTLE_TICKS, the FSM goes to ACTIVE on that cycle.
REQ-021 SETTLE: if mode_sw becomes a different valid code, candidate is reloaded and the count cleared; if mode_sw becomes invalid, the FSM goes to IDLE.
REQ-022 ACTIVE: if mode_sw becomes a different valid code, the FSM goes to SETTLE; grant keeps the old service until the new grant.
REQ-023 ACTIVE: if mode_sw becomes invalid, the FSM goes to IDLE and grant=0000 on the next clock.
REQ-024 In ACTIVE (and SETTLE with a prior grant), seg SHALL show the selected nibble of svc_data[grant] decoded:
- values 0-9 use standard patterns;
- nibbles A-F are blank (1111111).
REQ-025 If svc_valid of the granted service is low, every digit SHALL show a dash (seg=0111111).
REQ-026 With no grant, anode SHALL be 1111 and seg 1111111.
REQ-027 alarm_req high SHALL override every state:
- blink phase 1: anode cycles normally and seg=0000000 (all lit);
- blink phase 0: anode=1111.
REQ-028 The FSM SHALL continue its transitions during the alarm override; the override ends one clock after alarm_req falls.
REQ-029 A mode_sw change in the same cycle as a scan_tick SHALL be evaluated as the new value and SHALL NOT count toward settling.

Reset
REQ-030 With reset high at a clock edge, the module SHALL set:
- FSM to IDLE; grant=0000; candidate=0000; settling=0;
- anode=1111; seg=1111111;
- scan, digit-index, settle and blink counters to 0.
REQ-031 Reset mid-SETTLE or mid-ACTIVE SHALL abandon the transition; outputs return to idle values on the clock edge where reset is sampled.

Structure
REQ-032 A shared package SHALL hold:
- the SERVICE codes (RESET/1/2/3/4);
- the FSM state enum;
- the anode map constants;
- segment constants (BLANK, DASH, ALL_ON).
REQ-033 The BCD-to-segment decode SHALL be one combinational sub-module, bcd_to_seg (4-bit in, 7-bit active-low out); it is instantiated once in display_scheduler, and seg is registered in display_scheduler.
REQ-034 The expected implementation size is 150-300 lines of RTL; there SHALL be no other sub-modules.

Verification (SCAN_DIV_W=2, SETTLE_TICKS=4, BLINK_W=4)
REQ-035 Reset, then mode_sw=1000, svc_data0=16'h1234, svc_valid=1000:
- settling=1 for 4 scan ticks, then grant=1000;
- digits 0-3 show 4,3,2,1 on anodes 1011,0111,1110,1101.
REQ-036 In ACTIVE S1, set mode_sw=0100 for 2 ticks, then 0010:
- grant stays 1000 throughout;
- candidate reloads to 0010;
- grant=0010 after 4 further ticks.
REQ-037 mode_sw=1100 or 0000 in any state -> IDLE; anode=1111 and grant=0000 within 1 clock.
REQ-038 Granted S2 with svc_valid[2]=0 -> seg=0111111 on all digits; svc_data1=16'h00F5 -> digit 0 shows 5, digit 1 is blank.
REQ-039 alarm_req=1 while ACTIVE -> seg=0000000 and anode cycling for 8 clocks, then anode=1111 for 8 clocks, repeating; alarm_req=0 -> normal digits on the next clock.
REQ-040 Assert reset during SETTLE at tick 3 -> the next clock shows idle outputs; with mode_sw held, a full 4 ticks are needed again before grant.
